conway_pixel_fetch: RTL and testbench

- Display-side consumer of the Conway accelerator's read port; sits between the VGA timing generator and the accelerator.
- Converts VGA pixel coordinates into word reads (address_b / q_b / wait_request) and prefetches one word ahead so the stream never stalls.
- Unpacks 20-cell words into a per-pixel cell stream.
- Generates ready_sig, the once-per-frame "safe to swap generations" pulse.

---
 rtl/conway_pixel_fetch.sv | 138 +++++++++++++
 tb/tb_conway_pixel_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conway_pixel_fetch.sv
// conway_pixel_fetch: VGA-side word prefetcher and cell unpacker for the Conway accelerator read port.
// Define PIXEL_RGB_EN to replace cell_out with 24-bit rgb_out.
module conway_pixel_fetch #(
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 1024,
  parameter int V_TOTAL       = 1066,
  parameter int WORDS_PER_ROW = 64,
  parameter int WORD_W        = 20,
  parameter int RD_LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  output logic [15:0]       address_b,
  output logic              rd_req,
  input  logic [WORD_W-1:0] q_b,
  input  logic              wait_request,
  output logic              ready_sig,
`ifdef PIXEL_RGB_EN
  output logic [23:0]       rgb_out,
`else
  output logic              cell_out,
`endif
  output logic              cell_valid,
  output logic              underrun
);
  localparam int PW = $clog2(WORD_W);
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam int FW = $clog2(WORDS_PER_ROW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d, next_full_q, next_full_d, discard_q, discard_d;
  logic              underrun_q, underrun_d, ready_q, ready_d, valid_q, valid_d;
  logic [WORD_W-1:0] next_word_q, next_word_d, shift_q, shift_d, fresh;
  logic [PW-1:0]     phase_q, phase_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [FW-1:0]     fetch_word_q, fetch_word_d;
  logic [9:0]        fetch_row_q, fetch_row_d;
  logic [15:0]       addr_q, addr_d;
  logic [10:0]       vnext;
  logic              visible, trig, accept, done, capture, start, load, hole;
`ifdef PIXEL_RGB_EN
  logic [23:0]       pix_q, pix_d;
`else
  logic              pix_q, pix_d;
`endif

  always_comb begin
    visible = pix_en && hcount < 11'(H_ACTIVE) && vcount < 11'(V_ACTIVE);
    trig    = pix_en && hcount == 11'(H_ACTIVE);
    vnext   = (vcount + 11'd1 == 11'(V_TOTAL)) ? 11'd0 : vcount + 11'd1;
    accept  = state_q == S_ISSUE && !wait_request;
    done    = state_q == S_WAIT && lat_q == LW'(RD_LATENCY);
    capture = done && !discard_q;
    // never launch on a trigger cycle: the address would still belong to the old row
    start   = state_q == S_IDLE && armed_q && !next_full_q && !trig && fetch_word_q < FW'(WORDS_PER_ROW);
    load    = visible && phase_q == '0;
    hole    = load && !next_full_q && !capture;
    fresh   = next_full_q ? next_word_q : capture ? q_b : '0;
  end

  always_comb state_d = start ? S_ISSUE : accept ? S_WAIT : done ? S_IDLE : state_q;

  always_comb rd_req = state_q == S_ISSUE;

  always_comb begin
    armed_d      = trig ? vnext < 11'(V_ACTIVE) : armed_q;
    fetch_row_d  = (trig && vnext < 11'(V_ACTIVE)) ? vnext[9:0] : fetch_row_q;
    fetch_word_d = trig ? '0 : (accept && !discard_q) ? fetch_word_q + 1'b1 : fetch_word_q;
    discard_d    = (discard_q || (trig && state_q != S_IDLE)) && !done;
    addr_d       = start ? {fetch_row_q, 6'(fetch_word_q)} : addr_q;
    lat_d        = accept ? LW'(1) : state_q == S_WAIT ? lat_q + 1'b1 : '0;
    next_word_d  = capture ? q_b : next_word_q;
    next_full_d  = !trig && (capture ? !load : next_full_q && !load);
    phase_d      = trig ? '0 : !visible ? phase_q : phase_q == PW'(WORD_W - 1) ? '0 : phase_q + 1'b1;
    shift_d      = !visible ? shift_q : load ? fresh : shift_q << 1;
    underrun_d   = underrun_q || (hole && armed_q);
    valid_d      = visible;
    ready_d      = pix_en && hcount == '0 && vcount == 11'(V_ACTIVE);
`ifdef PIXEL_RGB_EN
    pix_d        = !visible ? 24'h000000 : shift_d[WORD_W-1] ? 24'hFFFFFF : 24'h000040;
`else
    pix_d        = visible && shift_d[WORD_W-1];
`endif
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q      <= 1'b0;
      next_full_q  <= 1'b0;
      discard_q    <= 1'b0;
      underrun_q   <= 1'b0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      next_word_q  <= '0;
      shift_q      <= '0;
      phase_q      <= '0;
      lat_q        <= '0;
      fetch_word_q <= '0;
      fetch_row_q  <= '0;
      addr_q       <= '0;
      pix_q        <= '0;
    end else begin
      armed_q      <= armed_d;
      next_full_q  <= next_full_d;
      discard_q    <= discard_d;
      underrun_q   <= underrun_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      next_word_q  <= next_word_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      lat_q        <= lat_d;
      fetch_word_q <= fetch_word_d;
      fetch_row_q  <= fetch_row_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
    end
  end

  assign address_b  = addr_q;
  assign ready_sig  = ready_q;
  assign cell_valid = valid_q;
  assign underrun   = underrun_q;
`ifdef PIXEL_RGB_EN
  assign rgb_out    = pix_q;
`else
  assign cell_out   = pix_q;
`endif
endmodule

// File: tb/tb_conway_pixel_fetch.sv
// tb_conway_pixel_fetch: randomized bench for conway_pixel_fetch on a reduced 80x12 geometry with a latency-2 memory model.
module tb_conway_pixel_fetch;
  localparam int HA = 80, VA = 12, VT = 14, HT = 96, WPR = 4, WW = 20;

  logic        clk = 1'b0, reset = 1'b1, pix_en = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic [15:0] address_b;
  logic        rd_req, wait_request, ready_sig, cell_valid, underrun;
  logic [19:0] q_b = '0;
`ifdef PIXEL_RGB_EN
  logic [23:0] pix_out;
`else
  logic        pix_out;
`endif

  conway_pixel_fetch #(.H_ACTIVE(HA), .V_ACTIVE(VA), .V_TOTAL(VT), .WORDS_PER_ROW(WPR), .WORD_W(WW), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .address_b(address_b), .rd_req(rd_req), .q_b(q_b), .wait_request(wait_request), .ready_sig(ready_sig),
`ifdef PIXEL_RGB_EN
    .rgb_out(pix_out),
`else
    .cell_out(pix_out),
`endif
    .cell_valid(cell_valid), .underrun(underrun));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

`ifdef PIXEL_RGB_EN
  function automatic logic [23:0] pix_val(input logic v, input logic b);
    return !v ? 24'h000000 : b ? 24'hFFFFFF : 24'h000040;
  endfunction
`else
  function automatic logic pix_val(input logic v, input logic b);
    return v && b;
  endfunction
`endif

  // memory: data for an accepted address is on q_b exactly two clocks later, junk otherwise
  logic [19:0] mem [0:65535];
  logic [19:0] p1_d = '0;
  logic        p1_v = 1'b0, p1_s = 1'b0, qv = 1'b0, q_s = 1'b0, cur_s = 1'b0, tb_trig;
  int          stall_cnt = 0, stall_len = 0, stall_lo = 0, stall_hi = 0;

  assign tb_trig      = reset || (pix_en && hcount == 11'(HA));
  assign wait_request = stall_cnt < stall_len;

  // *_s flags mark reads that a line trigger or reset has made stale
  always @(posedge clk) begin
    p1_v  <= rd_req && !wait_request;
    p1_d  <= mem[address_b];
    p1_s  <= rd_req && !wait_request && (cur_s || tb_trig);
    cur_s <= reset ? 1'b0 : (rd_req && !wait_request) ? 1'b0 : cur_s || (tb_trig && rd_req);
    qv    <= p1_v;
    q_s   <= p1_s || tb_trig;
    q_b   <= p1_v ? p1_d : 20'($urandom);
    if (reset) stall_cnt <= 0;
    else if (rd_req && !wait_request) begin
      stall_cnt <= 0;
      stall_len <= int'($urandom_range(stall_hi, stall_lo));
    end else if (rd_req) stall_cnt <= stall_cnt + 1;
  end

  // reference: one-word buffer between memory and a per-line word stream
  logic        armed_m = 0, slot_full = 0, under_m = 0, under_seen = 0, post_rst = 1, first_acc = 1;
  logic        exp_valid = 0, exp_bit = 0, exp_ready = 0, was_stall = 0;
  logic [19:0] slot_w = '0, cur_w = '0;
  logic [15:0] held_addr = '0;
  int          exp_row = 0, exp_k = 0, nready = 0;

  always @(negedge clk) begin
    logic trig, vis, acc, arr;
    int   x, l;
    if (reset) begin
      armed_m = 0; slot_full = 0; under_m = 0; under_seen = 0; post_rst = 1;
      exp_valid = 0; exp_bit = 0; exp_ready = 0; was_stall = 0;
    end
    chk("cell_valid", cell_valid, exp_valid);
    chk("pixel", pix_out, pix_val(exp_valid, exp_bit));
    chk("ready_sig", ready_sig, exp_ready);
    chk("underrun", underrun, under_m);
    if (ready_sig) nready++;
    if (reset) begin
      chk("rst_addr", address_b, 0);
      chk("rst_rd_req", rd_req, 0);
    end else begin
      trig = pix_en && hcount == 11'(HA);
      vis  = pix_en && hcount < 11'(HA) && vcount < 11'(VA);
      acc  = rd_req && !wait_request;
      if (post_rst) chk("rd_req_before_trigger", rd_req, 0);
      if (rd_req && was_stall) chk("addr_hold", address_b, held_addr);
      was_stall = rd_req && wait_request;
      held_addr = address_b;
      if (acc && !(cur_s || trig)) begin
        chk("fetch_addr", address_b, 16'(exp_row * 64 + exp_k));
        if (first_acc) begin
          chk("first_fetch_line", vcount, VT - 1);
          first_acc = 0;
        end
        exp_k++;
      end
      arr = qv && !q_s && !trig;
      x = int'(hcount);
      exp_valid = vis;
      exp_bit = 0;
      if (vis && armed_m) begin
        if (x % WW == 0) begin
          if (slot_full) begin
            cur_w = slot_w; slot_full = 0;
          end else if (arr) begin
            cur_w = q_b; arr = 0;
          end else begin
            cur_w = '0; under_m = 1; under_seen = 1;
          end
        end
        exp_bit = under_seen ? cur_w[WW-1-x%WW] : mem[16'(int'(vcount) * 64 + x / WW)][WW-1-x%WW];
      end
      if (arr) begin
        slot_full = 1; slot_w = q_b;
      end
      if (trig) begin
        l = (int'(vcount) + 1 == VT) ? 0 : int'(vcount) + 1;
        armed_m = l < VA; slot_full = 0; exp_row = l; exp_k = 0; post_rst = 0;
      end
      exp_ready = pix_en && hcount == 0 && vcount == 11'(VA);
    end
  end

  task automatic pix(input int h, input int v, input int gap);
    pix_en = 1'b1; hcount = 11'(h); vcount = 11'(v);
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic line(input int v, input int gmin, input int gmax, input int rst_h);
    for (int h = 0; h < HT; h++) begin
      if (h == rst_h) begin
        pix_en = 1'b0; reset = 1'b1;
        #1;
        chk("rst_now_pixel", pix_out, 0);
        chk("rst_now_valid", cell_valid, 0);
        chk("rst_now_rd_req", rd_req, 0);
        chk("rst_now_addr", address_b, 0);
        chk("rst_now_underrun", underrun, 0);
        chk("rst_now_ready", ready_sig, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
      pix(h, v, int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic frame(input int gmin, input int gmax, input int slo, input int shi, input int rst_v);
    stall_lo = slo; stall_hi = shi; nready = 0;
    for (int v = 0; v < VT; v++) line(v, gmin, gmax, v == rst_v ? 37 : -1);
    chk("ready_pulses_per_frame", nready, 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 20'($urandom);
    mem[16'h0000] = 20'h80001;
    mem[16'h0143] = 20'hFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr", address_b, 0);
    chk("reset_rd_req", rd_req, 0);
    chk("reset_pixel", pix_out, 0);
    chk("reset_underrun", underrun, 0);
    reset = 1'b0;
    line(VT - 1, 1, 1, -1);
    frame(1, 1, 0, 0, -1);
    frame(4, 4, 10, 10, -1);
    chk("no_underrun_stalled", underrun, 0);
    frame(1, 3, 0, 6, -1);
    frame(1, 1, 30, 30, -1);
    chk("underrun_sticky", underrun, 1);
    frame(1, 1, 0, 0, 6);
    frame(1, 2, 0, 3, -1);
    chk("no_underrun_after_reset", underrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
